// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  // 2'd3 is unused and decodes back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_addr.sv
// One-bit full adder built from two half-adder stages plus an OR of their carries.
module half_addr (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_addr (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  half_addr u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  half_addr u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands shift out LSB-first through one full-adder cell
// with a registered carry; sum/cout are presented with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted only in IDLE or DONE; the result is valid while
  // done=1 and holds until the next accepted start. No backpressure.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             s_bit, c_next;

  full_addr u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .cin(carry),
    .s  (s_bit),
    .co (c_next)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa      <= '0;
      sb      <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sa    <= a;
        sb    <= b;
        carry <= 1'b0;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state_q == S_SHIFT) begin
        sum   <= {s_bit, sum[WIDTH-1:1]};
        sa    <= {1'b0, sa[WIDTH-1:1]};
        sb    <= {1'b0, sb[WIDTH-1:1]};
        carry <= c_next;
        cnt   <= cnt + CNT_W'(1);
        if (cnt == LAST_CNT) cout <= c_next;
      end
    end
  end

  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for latency/control cases and a
// 4-bit instance swept over every operand pair back-to-back.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic [1:0] state;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
  logic [1:0] state4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .state(state)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state(state4)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one 8-bit add from IDLE/DONE; returns in the done cycle with outputs checked.
  task automatic run_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp_sum, input logic exp_cout);
    a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      step();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    step();

    // 3 + 5, then result holds in IDLE
    run_add("add_03_05", 8'h03, 8'h05, 8'h08, 1'b0);
    step();
    check("idle_done_lo", 32'(done), 32'd0);
    check("idle_state", 32'(state), 32'd0);
    check("idle_sum_hold", 32'(sum), 32'h08);
    step(); step();

    // Carry-out cases, second one started back-to-back from DONE
    run_add("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_add("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    step();

    // start and operand changes during SHIFT are ignored
    a = 8'h10; b = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0; a = 8'(8'h11 * i); b = 8'hC3;
      end
      check("ign_busy", 32'(busy), 32'd1);
      step();
    end
    start = 1'b0;
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum", 32'(sum), 32'h30);
    check("ign_cout", 32'(cout), 32'd0);
    step();

    // Reset in SHIFT cycle 4 discards the partial result
    a = 8'h7F; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    run_add("add_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0);
    step();

    // start held high: done pulses 9 cycles apart
    a = 8'h01; b = 8'h01; start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("hold1_busy", 32'(busy), 32'd1);
      step();
    end
    check("hold1_done", 32'(done), 32'd1);
    check("hold1_sum", 32'(sum), 32'h02);
    check("hold1_cout", 32'(cout), 32'd0);
    a = 8'h80; b = 8'h80;
    step();
    for (int i = 0; i < 8; i++) begin
      check("hold2_busy", 32'(busy), 32'd1);
      check("hold2_nodone", 32'(done), 32'd0);
      step();
    end
    check("hold2_done", 32'(done), 32'd1);
    check("hold2_sum", 32'(sum), 32'h00);
    check("hold2_cout", 32'(cout), 32'd1);
    start = 1'b0;
    step();
    check("hold_end_done", 32'(done), 32'd0);
    check("hold_end_busy", 32'(busy), 32'd0);

    // WIDTH=4 exhaustive sweep, back-to-back with a 5-cycle period
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("w4_busy", 32'(busy4), 32'd1);
        step(); step(); step(); step();
        check("w4_done", 32'(done4), 32'd1);
        check("w4_result", 32'({cout4, sum4}), 32'(x + y));
      end
    end
    step();
    check("w4_idle", 32'(done4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
